counter_updown_mod: RTL
=======================

Name: counter_updown_mod

Overview:
Parametrised modulo up/down counter, successor to the single-step 8-bit counter. Adds:
- programmable step and direction
- arbitrary modulus
- synchronous parallel load
- terminal-count pulse
- one-shot mode with a RUN/HALT state machine

Used as a general timebase or event counter. Decade counting (MAX_VAL=9) is the primary use.

Parameters:
WIDTH, 8, count register width in bits
MAX_VAL, 2**WIDTH-1, upper count bound; count range is 0..MAX_VAL inclusive; must satisfy 1 <= MAX_VAL <= 2**WIDTH-1
STEP_W, 4, width of step input; STEP_W <= WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  count enable; one step per enabled cycle
dir  input  1  1 = count up, 0 = count down
step  input  STEP_W  increment magnitude; values > MAX_VAL are treated as MAX_VAL
oneshot  input  1  0 = free-run (wrap), 1 = one-shot (halt at bound)
ld  input  1  synchronous load strobe
ld_val  input  WIDTH  load value; values > MAX_VAL are loaded as MAX_VAL
count  output  WIDTH  current count, registered
tc  output  1  terminal-count pulse, registered, one cycle wide
done  output  1  one-shot halted flag, registered

Behaviour:
- Reset (rst=0, asynchronous, independent of clk):
  - count=0, tc=0, done=0, state=RUN.
  - Reset while counting aborts immediately.
  - First update occurs on the first rising edge after rst returns to 1.
- Priority per edge: reset > ld > en.
- ld=1:
  - count <= min(ld_val, MAX_VAL); tc <= 0; done <= 0; state <= RUN.
  - en, dir and step are ignored that cycle.
- en=0 and ld=0: count holds; tc <= 0; state and done hold.
- step=0 with en=1: count holds, tc <= 0, no state change.
- Arithmetic, free-run (oneshot=0), with s = min(step, MAX_VAL) and an internal sum width of WIDTH+1 bits (no overflow at 2**WIDTH-1):
  - Up: if count+s > MAX_VAL, count <= count+s-(MAX_VAL+1) and tc <= 1; else count <= count+s, tc <= 0.
  - Down: if s > count, count <= count+(MAX_VAL+1)-s and tc <= 1; else count <= count-s, tc <= 0.
  - Reaching exactly MAX_VAL or 0 without crossing is not a wrap: tc stays 0.
- One-shot (oneshot=1), states RUN and HALT:
  - RUN, en=1, up: if count+s >= MAX_VAL, count <= MAX_VAL, tc <= 1, done <= 1, state <= HALT; else count <= count+s.
  - RUN, en=1, down: if s >= count, count <= 0, tc <= 1, done <= 1, state <= HALT; else count <= count-s.
  - HALT: en ignored; count and done hold; tc <= 0. Only ld or reset exits HALT.
  - oneshot sampled every cycle. Clearing it while in HALT does not leave HALT; only ld or reset exits.
- tc:
  - Asserts on the same edge the wrapped/bound count appears.
  - Deasserts on the next edge unless another wrap occurs.
  - Back-to-back wraps give consecutive tc=1 cycles.
- Latency: one clock from en/ld to count update. No combinational path from inputs to outputs.
- dir may change on any cycle; it takes effect on that cycle's step.

Optional Feature:
Macro COUNTER_SAT_EN.
- Defined: free-run mode saturates instead of wrapping.
  - Up crossing gives count <= MAX_VAL.
  - Down crossing gives count <= 0.
  - tc <= 1 on the saturating edge and on every subsequent enabled step that remains pinned at the bound.
  - One-shot behaviour is unchanged.
- Undefined: wrap behaviour as above. No saturation logic is synthesised.

Test Plan:
1. WIDTH=4, MAX_VAL=9, oneshot=0, dir=1, step=3, en=1 from count=0 -> count 3,6,9,2; tc=1 only in cycle with count=2.
2. MAX_VAL=9, ld_val=1 then dir=0, step=2, en=1 -> count 1,9 (tc=1),7,5,3,1,9 (tc=1).
3. MAX_VAL=9, oneshot=1, ld_val=7, dir=1, step=2 -> count 9, tc=1 for one cycle, done=1; further en=1 for 5 cycles -> count stays 9, tc=0; ld with ld_val=0 -> count 0, done=0.
4. ld=1, en=1 same cycle, ld_val=12, MAX_VAL=9 -> count=9, tc=0, no step applied; step=15, dir=1, en=1 next -> count=8 (9+9-10), tc=1.
5. Drive rst=0 mid-cycle between edges while count=6, done=1 -> count=0, done=0, tc=0 immediately without a clock edge; counting resumes on the first edge after rst=1.
6. COUNTER_SAT_EN defined, MAX_VAL=9, count=8, dir=1, step=4, en=1 x3 -> count 9,9,9 with tc=1 each cycle; without macro -> count 2,6,0 with tc=1,0,1.

Source files
------------

// File: rtl/counter_updown_mod_if.sv
// Control and status bundle for counter_updown_mod: the master drives the
// controls, the slave (the counter) returns the count and flags.
interface counter_updown_mod_if #(
   parameter int WIDTH  = 8,
   parameter int STEP_W = 4
);
   logic              en;
   logic              dir;
   logic [STEP_W-1:0] step;
   logic              oneshot;
   logic              ld;
   logic [WIDTH-1:0]  ld_val;
   logic [WIDTH-1:0]  count;
   logic              tc;
   logic              done;

   modport master (
      output en, dir, step, oneshot, ld, ld_val,
      input  count, tc, done
   );

   modport slave (
      input  en, dir, step, oneshot, ld, ld_val,
      output count, tc, done
   );
endinterface

// File: rtl/counter_updown_mod.sv
// Modulo up/down counter with programmable step, parallel load, terminal-count
// pulse and one-shot RUN/HALT mode. Define COUNTER_SAT_EN to saturate in free-run.
module counter_updown_mod #(
   parameter int WIDTH   = 8,
   parameter int MAX_VAL = 2**WIDTH-1,
   parameter int STEP_W  = 4
) (
   input logic               clk,
   input logic               rst,
   counter_updown_mod_if.slave bus
);

   typedef enum logic {RUN, HALT} state_t;

   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
   localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             done_q, done_d;

   // One extra bit so count+step never overflows even at MAX_VAL = 2**WIDTH-1.
   logic [WIDTH:0] cnt_ext, step_ext, s, sum_up;
   logic [WIDTH-1:0] diff_dn;

   assign cnt_ext  = {1'b0, count_q};
   assign step_ext = (WIDTH+1)'(bus.step);
   assign s        = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
   assign sum_up   = cnt_ext + s;
   assign diff_dn  = WIDTH'(cnt_ext - s);

`ifndef COUNTER_SAT_EN
   localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + 1'b1;
   logic [WIDTH:0] wrap_up, wrap_dn;
   assign wrap_up = sum_up - MOD_EXT;
   assign wrap_dn = cnt_ext + MOD_EXT - s;
`endif

   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      done_d  = done_q;
      state_d = state_q;

      if (bus.ld) begin
         count_d = (bus.ld_val > MAX_W) ? MAX_W : bus.ld_val;
         done_d  = 1'b0;
         state_d = RUN;
      end else if (bus.en && state_q == RUN && s != '0) begin
         if (bus.oneshot) begin
            if (bus.dir) begin
               if (sum_up >= MAX_EXT) begin
                  count_d = MAX_W;
                  tc_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = HALT;
               end else begin
                  count_d = WIDTH'(sum_up);
               end
            end else begin
               if (s >= cnt_ext) begin
                  count_d = '0;
                  tc_d    = 1'b1;
                  done_d  = 1'b1;
                  state_d = HALT;
               end else begin
                  count_d = diff_dn;
               end
            end
         end else if (bus.dir) begin
            if (sum_up > MAX_EXT) begin
               tc_d = 1'b1;
`ifdef COUNTER_SAT_EN
               count_d = MAX_W;
`else
               count_d = WIDTH'(wrap_up);
`endif
            end else begin
               count_d = WIDTH'(sum_up);
            end
         end else begin
            if (s > cnt_ext) begin
               tc_d = 1'b1;
`ifdef COUNTER_SAT_EN
               count_d = '0;
`else
               count_d = WIDTH'(wrap_dn);
`endif
            end else begin
               count_d = diff_dn;
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values; the reset branch is asynchronous and active-low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         count_q <= '0;
         tc_q    <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         tc_q    <= tc_d;
         done_q  <= done_d;
      end
   end

   assign bus.count = count_q;
   assign bus.tc    = tc_q;
   assign bus.done  = done_q;

endmodule
